stream_mux2_rr: RTL and testbench
=================================

# stream_mux2_rr

Two-input to one-output streaming merger with valid/ready handshakes, round-robin arbitration and a registered output stage. It is the merging counterpart of the team's 1x2 demultiplexer: it combines two producer streams onto one link and tags each beat with its source channel, so a downstream demux keyed on `out_sel` can split them again. It sits between two producers and a single shared consumer.

## Interface
- `W`, default 8: data width of each channel.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in0_valid` input 1: channel 0 beat available.
- `in0_ready` output 1: channel 0 beat accepted this cycle (when `in0_valid` is also high).
- `in0_data` input W: channel 0 payload.
- `in0_last` input 1: final beat of a channel 0 packet. Used only under packet lock.
- `in1_valid`, `in1_ready`, `in1_data`, `in1_last`: same meanings for channel 1.
- `out_valid` output 1: output register holds a beat.
- `out_ready` input 1: consumer accepts the output beat.
- `out_data` output W: registered payload.
- `out_sel` output 1: source channel of the current output beat (0 or 1).
- `out_last` output 1: registered copy of the source `inX_last`.

## Operation
- Load enable: `ld = ~out_valid | out_ready`.
- Arbitration is combinational from `in0_valid`, `in1_valid`, the priority pointer `prio` and the lock state.
  - Only one input valid: that channel is granted.
  - Both inputs valid: channel `prio` is granted.
  - No input valid: no grant.
- Ready outputs:
  - `inX_ready = ld & grant==X`.
  - At most one ready is high per cycle.
  - A ready never rises for a channel whose valid is low.
- On a transfer (`inX_valid & inX_ready`):
  - The output register loads data, X and last.
  - `out_valid` is set to 1.
  - `prio` is set to the channel that was not granted.
- When `ld` is 1 and no input is valid:
  - `out_valid` is cleared to 0.
  - `out_data`, `out_sel` and `out_last` hold their values.
- When `out_valid & ~out_ready` (stall): the output register and `prio` hold, and both readies are 0.
- Inputs must hold valid and data stable until they are accepted. The block does not check this.
- Data passes through unmodified; there is no width conversion.

## Timing
- Reset values:
  - `out_valid` = 0, `out_data` = 0, `out_sel` = 0, `out_last` = 0.
  - `prio` = 0, so channel 0 wins the first contention.
  - Lock cleared.
- Latency: a beat accepted at edge N is presented with `out_valid` = 1 after edge N.
- Throughput: one beat per cycle when `out_ready` is held high.
- Continuous contention with both valids held high gives a strict alternation 0,1,0,1…
- A simultaneous output pop and input accept in the same cycle is legal; the register reloads with no bubble.
- Asserting reset mid-operation discards any beat held in the output register. Inputs must re-present it; no partial state is retained.
- `ready` depends combinationally on `out_ready` and on both `valid` inputs. There is no path from ready to valid.

## Configuration
- `STREAM_MUX2_PKT_LOCK_EN` defined: packet-atomic arbitration.
  - Accepting a beat with `inX_last` = 0 locks the grant to channel X.
  - While locked, only channel X can be granted, even if the other channel is valid and holds priority. X's ready still follows `ld`.
  - Accepting a beat of X with `inX_last` = 1 clears the lock and sets `prio` to the other channel.
  - Reset clears the lock.
- Macro not defined:
  - Arbitration is per beat as described above.
  - `inX_last` is only forwarded to `out_last` and has no effect on grants.

## Test plan
- Reset then idle: hold `rst_n`=0 → all outputs 0. Release with both valids at 0 → `out_valid` stays 0 and both readies stay 0.
- Single channel: `in1` sends 0x11,0x22,0x33 with `out_ready`=1 → output carries 0x11,0x22,0x33 with `out_sel`=1, each one cycle after its acceptance, with no gaps.
- Contention: both valids held high, `in0` sends 0xA0–0xA3 and `in1` sends 0xB0–0xB3 → output sequence is A0,B0,A1,B1,A2,B2,A3,B3.
- Backpressure: `out_ready`=0 for 3 cycles while holding beat 0x5A → output stays stable, both readies stay 0, and 0x5A appears exactly once after release.
- Reset mid-stream: assert `rst_n`=0 while `out_valid`=1 → `out_valid` drops immediately (asynchronously) and `prio` returns to 0.
- With `STREAM_MUX2_PKT_LOCK_EN` defined: `in0` sends a 3-beat packet (last on beat 3) while `in1` is valid → three ch0 beats are output, then ch1. Without the macro the same stimulus gives the output order 0,1,0,1,0.

Source files
------------

// File: rtl/stream_mux2_rr.sv
// ============================================================================
// Module   : stream_mux2_rr
// Purpose  : 2:1 valid/ready stream merger with round-robin arbitration and a
//            registered output stage. Each output beat is tagged with its
//            source channel on out_sel.
// Options  : STREAM_MUX2_PKT_LOCK_EN -- packet-atomic arbitration keyed on inX_last
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_mux2_rr #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         in0_valid,
    output logic         in0_ready,
    input  logic [W-1:0] in0_data,
    input  logic         in0_last,

    input  logic         in1_valid,
    output logic         in1_ready,
    input  logic [W-1:0] in1_data,
    input  logic         in1_last,

    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_sel,
    output logic         out_last
);

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q,  out_data_d;
    logic         out_sel_q,   out_sel_d;
    logic         out_last_q,  out_last_d;
    logic         prio_q,      prio_d;

    logic         w_ld;
    logic         w_gnt_vld;
    logic         w_gnt_ch;
    logic         w_xfer;
    logic         w_xfer_last;

`ifdef STREAM_MUX2_PKT_LOCK_EN
    logic         lock_q,    lock_d;
    logic         lock_ch_q, lock_ch_d;
`endif

    assign w_ld = ~out_valid_q | out_ready;

    // Grant: per-beat round robin, or pinned to the locked channel mid-packet.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_ch  = 1'b0;
`ifdef STREAM_MUX2_PKT_LOCK_EN
        if (lock_q) begin
            w_gnt_vld = lock_ch_q ? in1_valid : in0_valid;
            w_gnt_ch  = lock_ch_q;
        end else
`endif
        if (in0_valid && in1_valid) begin
            w_gnt_vld = 1'b1;
            w_gnt_ch  = prio_q;
        end else if (in0_valid) begin
            w_gnt_vld = 1'b1;
            w_gnt_ch  = 1'b0;
        end else if (in1_valid) begin
            w_gnt_vld = 1'b1;
            w_gnt_ch  = 1'b1;
        end
    end

    assign in0_ready   = w_ld & w_gnt_vld & ~w_gnt_ch;
    assign in1_ready   = w_ld & w_gnt_vld &  w_gnt_ch;
    assign w_xfer      = w_ld & w_gnt_vld;
    assign w_xfer_last = w_gnt_ch ? in1_last : in0_last;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_last_d  = out_last_q;
        prio_d      = prio_q;
        if (w_xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = w_gnt_ch ? in1_data : in0_data;
            out_sel_d   = w_gnt_ch;
            out_last_d  = w_xfer_last;
            prio_d      = ~w_gnt_ch;
        end else if (w_ld) begin
            // Output drained with nothing granted: drop valid, keep payload.
            out_valid_d = 1'b0;
        end
    end

`ifdef STREAM_MUX2_PKT_LOCK_EN
    always_comb begin
        lock_d    = lock_q;
        lock_ch_d = lock_ch_q;
        if (w_xfer) begin
            lock_d    = ~w_xfer_last;
            lock_ch_d = w_gnt_ch;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q    <= 1'b0;
            lock_ch_q <= 1'b0;
        end else begin
            lock_q    <= lock_d;
            lock_ch_q <= lock_ch_d;
        end
    end
`else
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= 1'b0;
            out_last_q  <= 1'b0;
            prio_q      <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_last_q  <= out_last_d;
            prio_q      <= prio_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_last  = out_last_q;

endmodule

`default_nettype wire

// File: tb/tb_stream_mux2_rr.sv
// ============================================================================
// Module   : tb_stream_mux2_rr
// Purpose  : Directed self-checking bench for stream_mux2_rr.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_mux2_rr;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in0_valid, in0_ready, in0_last;
    logic [W-1:0] in0_data;
    logic         in1_valid, in1_ready, in1_last;
    logic [W-1:0] in1_data;
    logic         out_valid, out_ready, out_sel, out_last;
    logic [W-1:0] out_data;

    int n_chk  = 0;
    int n_fail = 0;

    stream_mux2_rr #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in0_data  (in0_data),
        .in0_last  (in0_last),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .in1_data  (in1_data),
        .in1_last  (in1_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int           i0, i1, ch;
        logic [W-1:0] exp_d;
        logic         exp_l;

        rst_n     = 1'b0;
        in0_valid = 1'b0; in0_data = '0; in0_last = 1'b0;
        in1_valid = 1'b0; in1_data = '0; in1_last = 1'b0;
        out_ready = 1'b0;

        // Reset then idle
        tick(); tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data,  0);
        check("rst_out_sel",   out_sel,   0);
        check("rst_out_last",  out_last,  0);
        check("rst_in0_ready", in0_ready, 0);
        check("rst_in1_ready", in1_ready, 0);
        rst_n = 1'b1;
        tick(); tick();
        check("idle_out_valid", out_valid, 0);
        check("idle_in0_ready", in0_ready, 0);
        check("idle_in1_ready", in1_ready, 0);

        // Single channel: in1 sends 11,22,33 back to back
        out_ready = 1'b1;
        in1_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in1_data = 8'h11 * (k + 1);
            #1;
            check("single_in1_ready", in1_ready, 1);
            check("single_in0_ready", in0_ready, 0);
            tick();
            check("single_out_valid", out_valid, 1);
            check("single_out_data",  out_data,  8'h11 * (k + 1));
            check("single_out_sel",   out_sel,   1);
        end
        in1_valid = 1'b0;
        tick();
        check("single_drain_valid", out_valid, 0);
        check("single_drain_hold",  out_data,  8'h33);

        // Contention: strict alternation A0,B0,A1,B1,...
        i0 = 0; i1 = 0;
        for (int k = 0; k < 8; k++) begin
            ch        = k % 2;
            in0_valid = (i0 < 4);
            in1_valid = (i1 < 4);
            in0_data  = 8'hA0 + i0[7:0];
            in1_data  = 8'hB0 + i1[7:0];
            #1;
            check("cont_ready", ch ? in1_ready : in0_ready, 1);
            check("cont_other_ready", ch ? in0_ready : in1_ready, 0);
            exp_d = ch ? (8'hB0 + i1[7:0]) : (8'hA0 + i0[7:0]);
            tick();
            check("cont_out_data", out_data, exp_d);
            check("cont_out_sel",  out_sel,  ch);
            if (ch == 1) i1++; else i0++;
        end
        in0_valid = 1'b0; in1_valid = 1'b0;
        tick();
        check("cont_drain_valid", out_valid, 0);

        // Backpressure: hold 5A for 3 stalled cycles
        in0_valid = 1'b1; in0_data = 8'h5A;
        tick();
        check("bp_load_data", out_data, 8'h5A);
        in0_valid = 1'b0;
        out_ready = 1'b0;
        in1_valid = 1'b1; in1_data = 8'h77;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_in0_ready", in0_ready, 0);
            check("bp_in1_ready", in1_ready, 0);
            tick();
            check("bp_out_valid", out_valid, 1);
            check("bp_out_data",  out_data,  8'h5A);
            check("bp_out_sel",   out_sel,   0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in1_ready, 1);
        tick();
        check("bp_next_data", out_data, 8'h77);
        check("bp_next_sel",  out_sel,  1);
        in1_valid = 1'b0;
        tick();
        check("bp_drain_valid", out_valid, 0);

        // Packet: in0 sends C0,C1,C2(last) while in1 offers D0,D1,D2(last)
        i0 = 0; i1 = 0;
        for (int k = 0; k < 6; k++) begin
`ifdef STREAM_MUX2_PKT_LOCK_EN
            ch = (k < 3) ? 0 : 1;
`else
            ch = (k < 5) ? (k % 2) : 1;
`endif
            in0_valid = (i0 < 3);
            in1_valid = (i1 < 3);
            in0_data  = 8'hC0 + i0[7:0];
            in1_data  = 8'hD0 + i1[7:0];
            in0_last  = (i0 == 2);
            in1_last  = (i1 == 2);
            exp_d = ch ? (8'hD0 + i1[7:0]) : (8'hC0 + i0[7:0]);
            exp_l = ch ? (i1 == 2) : (i0 == 2);
            tick();
            check("pkt_out_data", out_data, exp_d);
            check("pkt_out_sel",  out_sel,  ch);
            check("pkt_out_last", out_last, exp_l);
            if (ch == 1) i1++; else i0++;
        end
        in0_valid = 1'b0; in1_valid = 1'b0;
        in0_last  = 1'b0; in1_last  = 1'b0;
        tick();

        // Reset mid-stream: ch0 transfer leaves prio at 1, reset must restore 0
        in0_valid = 1'b1; in0_data = 8'h99;
        tick();
        check("mrst_loaded", out_valid, 1);
        out_ready = 1'b0;
        in0_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_out_valid", out_valid, 0);
        check("mrst_out_data",  out_data,  0);
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in0_valid = 1'b1; in0_data = 8'hE0;
        in1_valid = 1'b1; in1_data = 8'hF0;
        #1;
        check("mrst_prio_in0_ready", in0_ready, 1);
        check("mrst_prio_in1_ready", in1_ready, 0);
        tick();
        check("mrst_after_data", out_data, 8'hE0);
        check("mrst_after_sel",  out_sel,  0);
        in0_valid = 1'b0; in1_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
